// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_e        FSM states of the request/response sequencer
//   SZ_*           legal transfer sizes in bytes
//   LAT_MIN/MAX    legal range of the LATENCY parameter
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 15;

endpackage

// File: rtl/dmem_access_check.sv
// dmem_access_check: combinational legality check and byte-lane decode for
// one access.
//   DEPTH      (param) storage size in bytes
//   addr_i     full 64-bit byte address
//   size_i     transfer size in bytes
//   err_o      1 = illegal size, misaligned, or beyond storage
//   lane_en_o  lane i (bits [8i+7:8i] of right-justified data) is in use
module dmem_access_check
  import dmem_pkg::*;
#(
  parameter logic [64:0] DEPTH = 65'd1024
) (
  input  logic [63:0] addr_i,
  input  logic [3:0]  size_i,
  output logic        err_o,
  output logic [7:0]  lane_en_o
);

  logic        size_ok;
  logic        align_ok;
  logic        range_ok;
  logic [64:0] end_addr;

  always_comb begin
    size_ok  = (size_i == SZ_B) || (size_i == SZ_H) ||
               (size_i == SZ_W) || (size_i == SZ_D);
    // size-1 as a 3-bit mask: 1->0, 2->1, 4->3, 8->7 (8 wraps from 0).
    align_ok = (addr_i[2:0] & (size_i[2:0] - 3'd1)) == 3'd0;
    // 65-bit sum so addresses near 2**64 cannot wrap into range.
    end_addr = {1'b0, addr_i} + {61'd0, size_i};
    range_ok = end_addr <= DEPTH;
    err_o    = !(size_ok && align_ok && range_ok);
    for (int i = 0; i < 8; i++) begin
      lane_en_o[i] = int'(size_i) > i;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle big-endian data memory behind a valid/ready
// request/response handshake.
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready     request handshake; ready only in IDLE
//   req_write           1 = store, 0 = load
//   req_addr            byte address
//   req_wdata           store data, right-justified
//   req_size            transfer bytes (1/2/4/8)
//   rsp_valid/ready     response handshake; valid only in RESP
//   rsp_rdata           load data, zero-extended (0 for stores and errors)
//   rsp_err             access rejected
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH    = 2 ** ADDR_BITS;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("dmem_responder: LATENCY out of range");
  end

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [3:0]  size_q, size_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [7:0] mem_q [DEPTH];

  logic                      chk_err;
  logic [7:0]                lane_en;
  logic [7:0][ADDR_BITS-1:0] byte_idx;
  logic [63:0]               rd_data;
  logic                      do_access;

  dmem_access_check #(
    .DEPTH(65'(1) << ADDR_BITS)
  ) u_check (
    .addr_i   (addr_q),
    .size_i   (size_q),
    .err_o    (chk_err),
    .lane_en_o(lane_en)
  );

  // Lane i of right-justified data lives at addr+size-1-i (big-endian).
  // Indices of disabled lanes are don't-care.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      byte_idx[i]       = addr_q[ADDR_BITS-1:0] + ADDR_BITS'(int'(size_q) - 1 - i);
      rd_data[8*i +: 8] = lane_en[i] ? mem_q[byte_idx[i]] : 8'h00;
    end
  end

  assign do_access = (state_q == WAIT) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          err_d   = chk_err;
          rdata_d = (chk_err || wr_q) ? 64'd0 : rd_data;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      size_q  <= 4'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never cleared; reset only suppresses a store that would
  // commit on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && do_access && wr_q && !chk_err) begin
      for (int i = 0; i < 8; i++) begin
        if (lane_en[i]) mem_q[byte_idx[i]] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
